// File: rtl/mul_seq_hs_pkg.sv
// Shared definitions for the sequential shift-add handshake multiplier:
// 2-bit state encoding and a counter-width helper.
package mul_seq_pkg;

  localparam logic [1:0] WAIT = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StWait = WAIT,
    StCalc = CALC,
    StDone = DONE
  } state_e;

  // Bits needed to count 0..n-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mul_seq_hs_if.sv
// Handshake bundle between the two producers / product consumer and mul_seq_hs.
interface mul_seq_hs_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0]   x;
  logic           dav1_;
  logic           rfd1;
  logic [N-1:0]   y;
  logic           dav2_;
  logic           rfd2;
  logic [2*N-1:0] m;
  logic           ok;

  modport master (
    output x, dav1_, y, dav2_,
    input  rfd1, rfd2, m, ok
  );

  modport slave (
    input  x, dav1_, y, dav2_,
    output rfd1, rfd2, m, ok
  );
endinterface

// File: rtl/mul_seq_hs_step.sv
// One shift-add step: N-bit accumulator window plus X gated by the current
// multiplier bit, giving an N+1-bit sum that cannot overflow.
module mul_seq_step #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] acc_i,
  input  logic [N-1:0] x_i,
  input  logic         bit_i,
  output logic [N:0]   sum_o
);

  // Conditional add of the multiplicand into the accumulator window.
  always_comb begin
    sum_o = {1'b0, acc_i} + {1'b0, (bit_i ? x_i : '0)};
  end

endmodule

// File: rtl/mul_seq_hs.sv
// Sequential N x N shift-add multiplier with dav_/rfd handshake on two
// producer channels. One partial product per clock, N clocks of latency.
// Define MUL_SEQ_HS_SIGNED_EN for two's complement operands.
module mul_seq_hs
  import mul_seq_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input logic          clock,
  input logic          reset,
  mul_seq_hs_if.slave  bus
);

  localparam int unsigned CntW = clog2(N);

  state_e          state_q, state_d;
  logic            rfd_q, rfd_d;
  logic            ok_q, ok_d;
  logic [2*N-1:0]  m_q, m_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N-1:0]    xr_q, xr_d;
  logic [N-1:0]    yr_q, yr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N:0]      sum;

`ifdef MUL_SEQ_HS_SIGNED_EN
  logic neg_q, neg_d;
`endif

  // Bits of acc above cnt+N are still zero, so the step result overwrites
  // the window [cnt+N:cnt] without losing anything.
  mul_seq_step #(
    .N(N)
  ) u_step (
    .acc_i (acc_q[cnt_q +: N]),
    .x_i   (xr_q),
    .bit_i (yr_q[cnt_q]),
    .sum_o (sum)
  );

  // Next-state: handshake FSM, operand capture and accumulate.
  always_comb begin
    state_d = state_q;
    rfd_d   = rfd_q;
    ok_d    = ok_q;
    m_d     = m_q;
    acc_d   = acc_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    cnt_d   = cnt_q;
`ifdef MUL_SEQ_HS_SIGNED_EN
    neg_d   = neg_q;
`endif
    unique case (state_q)
      StWait: begin
        if (!bus.dav1_ && !bus.dav2_) begin
`ifdef MUL_SEQ_HS_SIGNED_EN
          xr_d  = bus.x[N-1] ? (~bus.x + 1'b1) : bus.x;
          yr_d  = bus.y[N-1] ? (~bus.y + 1'b1) : bus.y;
          neg_d = bus.x[N-1] ^ bus.y[N-1];
`else
          xr_d  = bus.x;
          yr_d  = bus.y;
`endif
          acc_d   = '0;
          cnt_d   = '0;
          rfd_d   = 1'b0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d[cnt_q +: N+1] = sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
`ifdef MUL_SEQ_HS_SIGNED_EN
          m_d = neg_q ? (~acc_d + 1'b1) : acc_d;
`else
          m_d = acc_d;
`endif
          ok_d    = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.dav1_ && bus.dav2_) begin
          ok_d    = 1'b0;
          rfd_d   = 1'b1;
          state_d = StWait;
        end
      end
      default: begin
        // Unused code recovers to WAIT with the handshake idle.
        rfd_d   = 1'b1;
        ok_d    = 1'b0;
        state_d = StWait;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StWait;
      rfd_q   <= 1'b1;
      ok_q    <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      xr_q    <= '0;
      yr_q    <= '0;
      cnt_q   <= '0;
`ifdef MUL_SEQ_HS_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rfd_q   <= rfd_d;
      ok_q    <= ok_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      cnt_q   <= cnt_d;
`ifdef MUL_SEQ_HS_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus.rfd1 = rfd_q;
  assign bus.rfd2 = rfd_q;
  assign bus.m    = m_q;
  assign bus.ok   = ok_q;

endmodule

// File: tb/tb_mul_seq_hs.sv
// Scoreboard bench for mul_seq_hs (N=8): stimulus pushes expected product and
// ok cycle; a negedge monitor pops and compares whenever ok rises.
module tb_mul_seq_hs;

  localparam int unsigned N = 8;

  typedef struct {
    logic [2*N-1:0] prod;
    int unsigned    cyc;
  } exp_t;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] e;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  vec_t        vecs[$];
  logic        ok_prev = 1'b0;

  mul_seq_hs_if #(.N(N)) bus ();

  mul_seq_hs #(
    .N(N)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare product and latency on every rising ok.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.ok === 1'b1 && !ok_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_ok", 64'(bus.ok), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("product", 64'(bus.m), 64'(e.prod));
          chk("latency", 64'(cyc), 64'(e.cyc));
        end
      end
      ok_prev = (bus.ok === 1'b1);
    end
  end

  task automatic capture(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] e, input bit push);
    @(negedge clock);
    bus.x = a;
    bus.y = b;
    bus.dav1_ = 1'b0;
    bus.dav2_ = 1'b0;
    @(negedge clock);
    chk("capture_rfd1", 64'(bus.rfd1), 64'd0);
    chk("capture_rfd2", 64'(bus.rfd2), 64'd0);
    if (push) sb.push_back('{prod: e, cyc: cyc + N});
  endtask

  task automatic wait_ok();
    int n;
    n = 0;
    while (bus.ok !== 1'b1 && n < 3 * N) begin
      @(negedge clock);
      n++;
    end
    if (bus.ok !== 1'b1) chk("ok_timeout", 64'(bus.ok), 64'd1);
  endtask

  task automatic hold_and_release(input logic [2*N-1:0] e);
    repeat (2) begin
      @(negedge clock);
      chk("done_ok_held", 64'(bus.ok), 64'd1);
      chk("done_m_stable", 64'(bus.m), 64'(e));
    end
    bus.dav1_ = 1'b1;
    bus.dav2_ = 1'b1;
    @(negedge clock);
    chk("release_ok", 64'(bus.ok), 64'd0);
    chk("release_rfd", 64'(bus.rfd1), 64'd1);
    chk("release_m_held", 64'(bus.m), 64'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.x = '0;
    bus.y = '0;
    bus.dav1_ = 1'b1;
    bus.dav2_ = 1'b1;

`ifdef MUL_SEQ_HS_SIGNED_EN
    vecs.push_back('{a: 8'd13,  b: 8'd11,  e: 16'd143});
    vecs.push_back('{a: 8'hFD,  b: 8'd5,   e: 16'hFFF1});
    vecs.push_back('{a: 8'h80,  b: 8'h80,  e: 16'h4000});
    vecs.push_back('{a: 8'd127, b: 8'hFF,  e: 16'hFF81});
`else
    vecs.push_back('{a: 8'd13,  b: 8'd11,  e: 16'd143});
    vecs.push_back('{a: 8'd255, b: 8'd255, e: 16'hFE01});
    vecs.push_back('{a: 8'd0,   b: 8'd200, e: 16'd0});
`endif

    // Reset state.
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("reset_rfd1", 64'(bus.rfd1), 64'd1);
    chk("reset_rfd2", 64'(bus.rfd2), 64'd1);
    chk("reset_ok", 64'(bus.ok), 64'd0);
    chk("reset_m", 64'(bus.m), 64'd0);

    // Directed vectors with full handshake.
    foreach (vecs[i]) begin
      capture(vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
      wait_ok();
      hold_and_release(vecs[i].e);
    end

    // Producer 1 alone must not start a capture.
    @(negedge clock);
    bus.x = 8'd7;
    bus.dav1_ = 1'b0;
    repeat (5) begin
      @(negedge clock);
      chk("single_dav_rfd", 64'(bus.rfd1), 64'd1);
    end
    capture(8'd7, 8'd9, 16'd63, 1'b1);
    wait_ok();
    hold_and_release(16'd63);

    // Reset sampled on the 4th CALC edge discards the operation.
    capture(8'd100, 8'd100, 16'd0, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    bus.dav1_ = 1'b1;
    bus.dav2_ = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midreset_rfd", 64'(bus.rfd1), 64'd1);
    chk("midreset_ok", 64'(bus.ok), 64'd0);
    chk("midreset_m", 64'(bus.m), 64'd0);
    capture(8'd3, 8'd5, 16'd15, 1'b1);
    wait_ok();
    hold_and_release(16'd15);

    // Partial release keeps DONE.
    capture(8'd2, 8'd3, 16'd6, 1'b1);
    wait_ok();
    bus.dav1_ = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("partial_ok", 64'(bus.ok), 64'd1);
      chk("partial_rfd", 64'(bus.rfd2), 64'd0);
    end
    bus.dav2_ = 1'b1;
    @(negedge clock);
    chk("final_release_ok", 64'(bus.ok), 64'd0);
    chk("final_release_rfd", 64'(bus.rfd2), 64'd1);

    repeat (2) @(negedge clock);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
